// File: rtl/bus_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter8
// Description : Eight-way round-robin arbiter with tenure limit and a
//               one-hot grant decoded from a registered grant index.
// Revision    : 1.0 - initial release
// ============================================================================

module bus_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [7:0] c_hold_last = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_vld;
    logic       r_timeout;
    logic [7:0] r_hold_cnt;

    logic [2:0] w_winner;
    logic [2:0] w_cand;

    // Scan from the farthest offset down so the nearest requester to r_ptr wins.
    always_comb begin
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            w_cand = r_ptr + 3'(i);
            if (req[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 3'd0;
            r_gnt_idx  <= 3'd0;
            r_gnt_vld  <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state    <= S_GRANT;
                        r_gnt_idx  <= w_winner;
                        r_gnt_vld  <= 1'b1;
                        r_hold_cnt <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (!req[r_gnt_idx]) begin
                        r_state   <= S_IDLE;
                        r_gnt_vld <= 1'b0;
                        r_ptr     <= r_gnt_idx + 3'd1;
                    end else if ((MAX_HOLD != 0) && (r_hold_cnt == c_hold_last)) begin
                        // Revoked owner drops to lowest priority for the next round.
                        r_state   <= S_IDLE;
                        r_gnt_vld <= 1'b0;
                        r_timeout <= 1'b1;
                        r_ptr     <= r_gnt_idx + 3'd1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign gnt     = r_gnt_vld ? (8'b1 << r_gnt_idx) : 8'b0;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter8
// Description : Self-checking bench for bus_arbiter8 (MAX_HOLD=4 and 0).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_bus_arbiter8;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] req_a, req_b;
    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       vld_a, vld_b;
    logic       to_a, to_b;

    int n_checks = 0;
    int n_fail   = 0;
    int to_seen_b = 0;

    always #5 clk = ~clk;

    bus_arbiter8 #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .timeout(to_a)
    );

    bus_arbiter8 #(.MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .timeout(to_b)
    );

    // Model: owner (-1 = none), cycles granted so far, last grantee, search start.
    int m_owner [2];
    int m_tenure[2];
    int m_last  [2];
    int m_start [2];
    int m_to    [2];
    int m_max   [2];

    task automatic model_step(input int d, input logic r, input logic [7:0] rq);
        int w;
        if (r) begin
            m_owner[d] = -1; m_tenure[d] = 0; m_last[d] = 0;
            m_start[d] = 0;  m_to[d] = 0;
        end else begin
            m_to[d] = 0;
            if (m_owner[d] < 0) begin
                if (rq != 8'h00) begin
                    w = -1;
                    for (int k = 0; k < 8; k++)
                        if (w < 0 && rq[(m_start[d] + k) % 8]) w = (m_start[d] + k) % 8;
                    m_owner[d] = w; m_last[d] = w; m_tenure[d] = 1;
                end
            end else if (!rq[m_owner[d]]) begin
                m_start[d] = (m_owner[d] + 1) % 8;
                m_owner[d] = -1;
            end else if (m_max[d] != 0 && m_tenure[d] == m_max[d]) begin
                m_to[d]    = 1;
                m_start[d] = (m_owner[d] + 1) % 8;
                m_owner[d] = -1;
            end else begin
                m_tenure[d] = m_tenure[d] + 1;
            end
        end
    endtask

    initial begin
        m_max[0] = 4;
        m_max[1] = 0;
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_tenure[d] = 0; m_last[d] = 0; m_start[d] = 0; m_to[d] = 0;
        end
    end

    always @(posedge clk or posedge rst_a) model_step(0, rst_a, req_a);
    always @(posedge clk or posedge rst_b) model_step(1, rst_b, req_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic [7:0] g, input logic [2:0] ix,
                           input logic v, input logic t);
        logic [7:0] eg;
        eg = (m_owner[d] >= 0) ? (8'h01 << m_last[d]) : 8'h00;
        chk($sformatf("model%0d gnt", d),     {24'h0, g},  {24'h0, eg});
        chk($sformatf("model%0d gnt_idx", d), {29'h0, ix}, 32'(m_last[d]));
        chk($sformatf("model%0d gnt_vld", d), {31'h0, v},  32'(m_owner[d] >= 0));
        chk($sformatf("model%0d timeout", d), {31'h0, t},  32'(m_to[d]));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, gnt_a, idx_a, vld_a, to_a);
        cmp_dut(1, gnt_b, idx_b, vld_b, to_b);
        if (to_b) to_seen_b++;
    end

    task automatic nxt;
        @(negedge clk);
        #1;
    endtask

    task automatic reset_a;
        rst_a = 1'b1;
        nxt();
        rst_a = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; req_a = 8'h00; req_b = 8'h00;
        repeat (2) nxt();
        rst_a = 1'b0; rst_b = 1'b0;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            nxt();
            chk("idle gnt", {24'h0, gnt_a}, 32'h0);
            chk("idle vld", {31'h0, vld_a}, 32'h0);
            chk("idle timeout", {31'h0, to_a}, 32'h0);
        end

        // All request, MAX_HOLD=4: 4 grant cycles + 1 timeout/idle cycle each
        req_a = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                nxt();
                chk("rr gnt", {24'h0, gnt_a}, {24'h0, 8'h01 << (k % 8)});
            end
            nxt();
            chk("rr gap gnt", {24'h0, gnt_a}, 32'h0);
            chk("rr timeout", {31'h0, to_a}, 32'h1);
        end
        req_a = 8'h00;
        nxt();

        // Early release by requester 0, then requester 7
        reset_a();
        req_a = 8'h81;
        for (int c = 0; c < 3; c++) begin
            nxt();
            chk("rel gnt0", {24'h0, gnt_a}, 32'h01);
        end
        req_a = 8'h80;
        nxt();
        chk("rel idle", {24'h0, gnt_a}, 32'h00);
        chk("rel no timeout", {31'h0, to_a}, 32'h0);
        nxt();
        chk("rel gnt7", {24'h0, gnt_a}, 32'h80);
        chk("rel idx7", {29'h0, idx_a}, 32'h7);
        req_a = 8'h00;
        nxt();
        chk("rel idx hold", {29'h0, idx_a}, 32'h7);

        // Pointer wrap: releases of 1..6 leave ptr at 7
        reset_a();
        for (int i = 1; i <= 6; i++) begin
            req_a = 8'h01 << i;
            nxt();
            chk("wrap single", {24'h0, gnt_a}, {24'h0, 8'h01 << i});
            req_a = 8'h00;
            nxt();
            chk("wrap gap", {24'h0, gnt_a}, 32'h0);
        end
        req_a = 8'h41;
        nxt();
        chk("wrap gnt0", {24'h0, gnt_a}, 32'h01);
        chk("wrap idx0", {29'h0, idx_a}, 32'h0);
        req_a = 8'h00;
        nxt();

        // Asynchronous reset mid-grant
        reset_a();
        req_a = 8'h10;
        nxt();
        chk("arst pre gnt", {24'h0, gnt_a}, 32'h10);
        #2;
        rst_a = 1'b1;
        #1;
        chk("arst gnt", {24'h0, gnt_a}, 32'h00);
        chk("arst vld", {31'h0, vld_a}, 32'h0);
        chk("arst idx", {29'h0, idx_a}, 32'h0);
        req_a = 8'h30;
        nxt();
        rst_a = 1'b0;
        nxt();
        chk("arst regrant", {24'h0, gnt_a}, 32'h10);
        chk("arst regrant idx", {29'h0, idx_a}, 32'h4);
        req_a = 8'h00;
        nxt();

        // Unlimited hold
        req_b = 8'h02;
        repeat (300) nxt();
        chk("nolimit gnt", {24'h0, gnt_b}, 32'h02);
        chk("nolimit no timeouts", 32'(to_seen_b), 32'h0);
        req_b = 8'h00;
        nxt();
        chk("nolimit release", {24'h0, gnt_b}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
